// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch aligner.
//   state_t        fetch FSM states
//   WORD_BYTES     bytes per memory word
//   DEFAULT_DEPTH  default byte capacity of the prefetch ring
//   size_to_bytes  decoder size code (2'b00 = 4, else 1..3) to a byte count
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 16;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 3'd4 : {1'b0, sz};
  endfunction

endpackage

// File: rtl/instr_fetch_aligner_byte_ring.sv
// byte_ring: DEPTH x 8 storage for the prefetch queue.
// Ports:
//   i_clk      clock
//   i_wr_en    write the upper (4 - i_wr_drop) bytes of i_wr_word
//   i_wr_ptr   ring slot receiving the first written byte
//   i_wr_drop  number of low-order word bytes skipped (start offset)
//   i_wr_word  memory word, byte 0 in [7:0]
//   i_rd_ptr   ring slot of the first window byte
//   o_rd_word  4 bytes from i_rd_ptr as they will be after this cycle's write
// Pointer and occupancy bookkeeping lives in the parent.
module byte_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [1:0]       i_wr_drop,
  input  logic [31:0]      i_wr_word,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output logic [31:0]      o_rd_word
);

  logic [7:0]       mem [DEPTH];
  logic [31:0]      shifted;
  logic [2:0]       wr_cnt;
  logic [PTR_W-1:0] pos [4];
  logic [PTR_W-1:0] off [4];

  // Kept bytes are moved down to byte lane 0 so lane k lands at wr_ptr + k.
  always_comb begin
    shifted = i_wr_word >> {i_wr_drop, 3'b000};
    wr_cnt  = 3'd4 - {1'b0, i_wr_drop};
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < wr_cnt) mem[i_wr_ptr + PTR_W'(k)] <= shifted[8*k +: 8];
      end
    end
  end

  // Read-through forwarding: a window byte written in this same cycle is
  // taken from the incoming word, so the registered window in the parent
  // is coherent with the ring contents after the edge.
  always_comb begin
    o_rd_word = '0;
    for (int j = 0; j < 4; j++) begin
      pos[j] = i_rd_ptr + PTR_W'(j);
      off[j] = pos[j] - i_wr_ptr;
      if (i_wr_en && (off[j] < PTR_W'(wr_cnt)))
        o_rd_word[8*j +: 8] = shifted[{off[j][1:0], 3'b000} +: 8];
      else
        o_rd_word[8*j +: 8] = mem[pos[j]];
    end
  end

endmodule

// File: rtl/instr_fetch_aligner.sv
// instr_fetch_aligner: instruction prefetch queue feeding the decoder.
// Fetches little-endian 32-bit words into a byte ring and presents a
// byte-aligned 4-byte window; advances by the decoded instruction size and
// flushes on redirect, discarding any response still in flight.
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   o_mem_req, o_mem_addr       single-cycle word fetch request
//   i_mem_valid, i_mem_data     fetch response (one per request)
//   o_ready, o_data, o_pc       window valid, 4 bytes, address of byte 0
//   i_consume, i_instr_size     decoder consumed 1..4 bytes (2'b00 = 4)
//   i_redirect, i_redirect_addr flush and restart at any byte address
// Optional (macro FETCH_STATS_EN):
//   o_stall_cycles              saturating count of starved cycles
//   o_redirects                 saturating count of redirects
module instr_fetch_aligner
  import fetch_pkg::*;
#(
  parameter int          DEPTH        = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_data,
  output logic        o_ready,
  output logic [31:0] o_data,
  output logic [31:0] o_pc,
  input  logic        i_consume,
  input  logic [1:0]  i_instr_size,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_redirects
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d, pc_d;
  logic [1:0]       drop_q, drop_d;
  logic             space_ok, issue, fill, cons;
  logic [2:0]       cons_n, fill_n;
  logic [31:0]      rd_word;

  // Registered count only: a fill can never land in the same cycle as an
  // issue, so the ring cannot overflow.
  assign space_ok = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WORD_BYTES);
  assign fill     = (state_q == S_WAIT) && i_mem_valid && !i_redirect;
  assign cons     = i_consume && o_ready && !i_redirect;
  assign cons_n   = size_to_bytes(i_instr_size);
  assign fill_n   = 3'd4 - {1'b0, drop_q};

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!i_redirect && space_ok) state_d = S_WAIT;
      S_WAIT:    if (i_mem_valid) state_d = S_IDLE;
                 else if (i_redirect) state_d = S_DISCARD;
      S_DISCARD: if (i_mem_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    issue = (state_q == S_IDLE) && !i_redirect && space_ok;
  end

  // ---- Queue bookkeeping: redirect wins over fill and consume ----
  always_comb begin
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    pc_d         = o_pc;
    if (i_redirect) begin
      count_d      = '0;
      head_d       = tail_q;
      pc_d         = i_redirect_addr;
      fetch_addr_d = {i_redirect_addr[31:2], 2'b00};
      drop_d       = i_redirect_addr[1:0];
    end else begin
      count_d = count_q + (fill ? CNT_W'(fill_n) : '0) - (cons ? CNT_W'(cons_n) : '0);
      if (fill) begin
        tail_d       = tail_q + PTR_W'(fill_n);
        fetch_addr_d = fetch_addr_q + 32'd4;
        drop_d       = 2'd0;
      end
      if (cons) begin
        head_d = head_q + PTR_W'(cons_n);
        pc_d   = o_pc + 32'(cons_n);
      end
    end
  end

  byte_ring #(.DEPTH(DEPTH)) u_ring (
    .i_clk     (i_clk),
    .i_wr_en   (fill),
    .i_wr_ptr  (tail_q),
    .i_wr_drop (drop_q),
    .i_wr_word (i_mem_data),
    .i_rd_ptr  (head_d),
    .o_rd_word (rd_word)
  );

  // ---- Registered state and decoder-facing outputs ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      fetch_addr_q <= {RESET_VECTOR[31:2], 2'b00};
      drop_q       <= RESET_VECTOR[1:0];
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_ready      <= 1'b0;
      o_data       <= '0;
      o_pc         <= RESET_VECTOR;
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      o_mem_req    <= issue;
      if (issue) o_mem_addr <= fetch_addr_q;
      o_ready      <= (count_d >= CNT_W'(WORD_BYTES));
      o_data       <= rd_word;
      o_pc         <= pc_d;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // Waiting on a response that will be thrown away is not counted as a stall.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cycles <= '0;
      o_redirects    <= '0;
    end else begin
      if (!o_ready && (state_q != S_DISCARD)) o_stall_cycles <= sat_inc32(o_stall_cycles);
      if (i_redirect) o_redirects <= sat_inc16(o_redirects);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_aligner.sv
module tb_instr_fetch_aligner;

  localparam int          DEPTH = 16;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        o_ready;
  logic [31:0] o_data;
  logic [31:0] o_pc;
  logic        i_consume = 1'b0;
  logic [1:0]  i_instr_size = 2'd0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_addr = '0;
`ifdef FETCH_STATS_EN
  logic [31:0] o_stall_cycles;
  logic [15:0] o_redirects;
`endif

  always #5 i_clk = ~i_clk;

  instr_fetch_aligner #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_valid     (i_mem_valid),
    .i_mem_data      (i_mem_data),
    .o_ready         (o_ready),
    .o_data          (o_data),
    .o_pc            (o_pc),
    .i_consume       (i_consume),
    .i_instr_size    (i_instr_size),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr)
`ifdef FETCH_STATS_EN
    ,
    .o_stall_cycles  (o_stall_cycles),
    .o_redirects     (o_redirects)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Memory image: byte at address a is a[7:0] + a[15:8].
  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] + a[15:8];
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } win_t;
  win_t sb[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] req_log[$];
  int          cyc = 0;
  int          resp_lat = 1;
  bit          resp_hold = 1'b0;

  // Memory responder: answers each request resp_lat cycles later unless held.
  initial begin
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      i_mem_valid = 1'b0;
      if (!resp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
        i_mem_valid = 1'b1;
        i_mem_data  = exp_word(pend[0].addr);
        void'(pend.pop_front());
      end
      if (o_mem_req) begin
        req_log.push_back(o_mem_addr);
        pend.push_back(pend_t'{o_mem_addr, cyc + resp_lat});
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic consume(input logic [1:0] sz);
    i_consume    = 1'b1;
    i_instr_size = sz;
    tick();
    i_consume    = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] a);
    i_redirect      = 1'b1;
    i_redirect_addr = a;
    req_log.delete();
    tick();
    i_redirect      = 1'b0;
  endtask

  task automatic test_reset();
    win_t w;
    bit ok;
    tick();
    tick();
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", o_mem_req); end
    checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", o_mem_addr); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", o_ready); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", o_data); end
    checks++; if (o_pc !== RV) begin errors++; $display("FAIL rst_pc got %h want %h", o_pc, RV); end
    i_reset_n = 1'b1;
    tick();
    checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100) begin
      errors++; $display("FAIL first_req got %b/%h want 1/00000100", o_mem_req, o_mem_addr);
    end
    sb.push_back(win_t'{32'h100, 32'h0403_0201});
    wait_ready(ok);
    w = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL first_ready timeout got 0 want 1"); end
    checks++; if (o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL first_window got %h/%h want %h/%h", o_pc, o_data, w.pc, w.data);
    end
  endtask

  task automatic test_consume();
    logic [1:0]  sizes [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [31:0] pc = RV;
    win_t w;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL cons_ready[%0d] timeout got 0 want 1", i); end
      consume(sizes[i]);
      pc = pc + ((sizes[i] == 2'd0) ? 32'd4 : 32'(sizes[i]));
      sb.push_back(win_t'{pc, exp_word(pc)});
      wait_ready(ok);
      w = sb.pop_front();
      checks++; if (!ok || o_pc !== w.pc || o_data !== w.data) begin
        errors++; $display("FAIL cons_window[%0d] got %h/%h want %h/%h", i, o_pc, o_data, w.pc, w.data);
      end
    end
  endtask

  task automatic test_redirect_unaligned();
    win_t w;
    bit ok;
    redirect(32'h203);
    checks++; if (o_ready !== 1'b0 || o_pc !== 32'h203) begin
      errors++; $display("FAIL redir_state got %b/%h want 0/00000203", o_ready, o_pc);
    end
    consume(2'd0);
    checks++; if (o_pc !== 32'h203) begin errors++; $display("FAIL consume_not_ready pc got %h want 00000203", o_pc); end
    sb.push_back(win_t'{32'h203, exp_word(32'h203)});
    wait_ready(ok);
    w = sb.pop_front();
    checks++; if (!ok || req_log.size() < 2) begin
      errors++; $display("FAIL redir_two_words got ready=%b reqs=%0d want 1/2", ok, req_log.size());
    end else if (req_log[0] !== 32'h200 || req_log[1] !== 32'h204) begin
      errors++; $display("FAIL redir_addrs got %h,%h want 00000200,00000204", req_log[0], req_log[1]);
    end
    checks++; if (o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL redir_window got %h/%h want %h/%h", o_pc, o_data, w.pc, w.data);
    end
  endtask

  task automatic test_redirect_in_wait();
    win_t w;
    bit ok;
    resp_lat = 3;
    redirect(32'h300);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) tick();
    checks++; if (req_log.size() == 0) begin errors++; $display("FAIL wait_req timeout got 0 want 1"); end
    redirect(32'h400);
    sb.push_back(win_t'{32'h400, exp_word(32'h400)});
    wait_ready(ok);
    w = sb.pop_front();
    checks++; if (!ok || req_log.size() == 0 || req_log[0] !== 32'h400) begin
      errors++; $display("FAIL discard_next_req got reqs=%0d first=%h want 00000400", req_log.size(),
                         (req_log.size() > 0) ? req_log[0] : 32'hx);
    end
    checks++; if (o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL discard_window got %h/%h want %h/%h", o_pc, o_data, w.pc, w.data);
    end
    resp_lat = 1;
  endtask

  task automatic test_stall();
    win_t w;
    redirect(32'h500);
    for (int i = 0; i < 40; i++) tick();
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL stall_reqs got %0d want 4", req_log.size()); end
    checks++; if (o_ready !== 1'b1 || o_pc !== 32'h500 || o_data !== exp_word(32'h500)) begin
      errors++; $display("FAIL stall_window got %b/%h/%h want 1/00000500/%h", o_ready, o_pc, o_data, exp_word(32'h500));
    end
    consume(2'd0);
    sb.push_back(win_t'{32'h504, exp_word(32'h504)});
    for (int i = 0; i < 20; i++) tick();
    w = sb.pop_front();
    checks++; if (req_log.size() != 5) begin errors++; $display("FAIL stall_one_more got %0d want 5", req_log.size()); end
    checks++; if (o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL stall_after_window got %h/%h want %h/%h", o_pc, o_data, w.pc, w.data);
    end
  endtask

  task automatic test_fill_and_consume();
    win_t w;
    redirect(32'h602);
    for (int i = 0; i < 30 && req_log.size() < 3; i++) tick();
    resp_hold = 1'b1;
    checks++; if (req_log.size() != 3 || o_ready !== 1'b1 || o_pc !== 32'h602) begin
      errors++; $display("FAIL six_bytes got reqs=%0d ready=%b pc=%h want 3/1/00000602", req_log.size(), o_ready, o_pc);
    end
    // Release the held response so it lands in the same cycle as the consume.
    resp_hold = 1'b0;
    tick();
    i_consume    = 1'b1;
    i_instr_size = 2'd2;
    resp_hold    = 1'b1;
    sb.push_back(win_t'{32'h604, exp_word(32'h604)});
    tick();
    i_consume = 1'b0;
    w = sb.pop_front();
    checks++; if (o_ready !== 1'b1 || o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL simul_window got %b/%h/%h want 1/%h/%h", o_ready, o_pc, o_data, w.pc, w.data);
    end
    consume(2'd0);
    checks++; if (o_ready !== 1'b1 || o_pc !== 32'h608 || o_data !== exp_word(32'h608)) begin
      errors++; $display("FAIL simul_count8 got %b/%h/%h want 1/00000608/%h", o_ready, o_pc, o_data, exp_word(32'h608));
    end
    consume(2'd0);
    checks++; if (o_ready !== 1'b0 || o_pc !== 32'h60C) begin
      errors++; $display("FAIL simul_drained got %b/%h want 0/0000060c", o_ready, o_pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    win_t w;
    bit ok;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0 || o_ready !== 1'b0 || o_data !== 32'h0 || o_pc !== RV) begin
      errors++; $display("FAIL async_reset got %b/%h/%b/%h/%h want 0/0/0/0/%h", o_mem_req, o_mem_addr, o_ready, o_data, o_pc, RV);
    end
    resp_hold = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    req_log.delete();
    i_reset_n = 1'b1;
    sb.push_back(win_t'{RV, 32'h0403_0201});
    wait_ready(ok);
    w = sb.pop_front();
    checks++; if (!ok || req_log.size() == 0 || req_log[0] !== RV) begin
      errors++; $display("FAIL post_reset_req got ready=%b reqs=%0d want 1/addr %h", ok, req_log.size(), RV);
    end
    checks++; if (o_pc !== w.pc || o_data !== w.data) begin
      errors++; $display("FAIL post_reset_window got %h/%h want %h/%h", o_pc, o_data, w.pc, w.data);
    end
  endtask

  initial begin
    test_reset();
    test_consume();
    test_redirect_unaligned();
    test_redirect_in_wait();
    test_stall();
    test_fill_and_consume();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
